// File: rtl/lcd_pkg.sv
// Shared LCD text-generation definitions: FSM states, HD44780 command bytes, ASCII helpers.
// Used by the sum-display block and later numeric display blocks.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONV,
      ST_CMD,
      ST_TEXT,
      ST_DIGS,
      ST_FIN
   } lcd_state_t;

   localparam logic [7:0] LCD_LINE1   = 8'h80;
   localparam logic [7:0] LCD_CLEAR   = 8'h01;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam int MSG_LEN = 11;
   localparam int DIG_LEN = 3;

   // A blanked digit renders as a space so leading zeros disappear on the display.
   function automatic logic [7:0] digit_char(input logic [3:0] d, input logic blank);
      return blank ? ASCII_SPACE : (ASCII_ZERO + {4'd0, d});
   endfunction

endpackage

// File: rtl/lcd_sum_text_gen_if.sv
// Byte channel from a text generator to the LCD nibble driver (valid/ready, RS flag as char_cmd).
interface lcd_sum_text_gen_if;

   logic [7:0] char_data;
   logic       char_cmd;
   logic       char_valid;
   logic       char_ready;

   modport master (
      output char_data,
      output char_cmd,
      output char_valid,
      input  char_ready
   );

   modport slave (
      input  char_data,
      input  char_cmd,
      input  char_valid,
      output char_ready
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit double-dabble: loads on start, runs 8 shift-add-3 steps, pulses done.
// Outputs hold their value until the next start; start while running restarts the conversion.
module bin2bcd_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] bin,
   output logic       done,
   output logic [3:0] hund,
   output logic [3:0] tens,
   output logic [3:0] units
);

   logic [7:0]  sh;
   logic [11:0] bcd;
   logic [11:0] adj;
   logic [2:0]  cnt;
   logic        run;

   always_comb begin
      adj = bcd;
      if (bcd[3:0]  >= 4'd5) adj[3:0]  = bcd[3:0]  + 4'd3;
      if (bcd[7:4]  >= 4'd5) adj[7:4]  = bcd[7:4]  + 4'd3;
      if (bcd[11:8] >= 4'd5) adj[11:8] = bcd[11:8] + 4'd3;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh   <= '0;
         bcd  <= '0;
         cnt  <= '0;
         run  <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            sh  <= bin;
            bcd <= '0;
            cnt <= '0;
            run <= 1'b1;
         end else if (run) begin
            {bcd, sh} <= {adj[10:0], sh, 1'b0};
            cnt       <= cnt + 3'd1;
            if (cnt == 3'd7) begin
               run  <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign hund  = bcd[11:8];
   assign tens  = bcd[7:4];
   assign units = bcd[3:0];

endmodule

// File: rtl/lcd_sum_text_gen.sv
// Adds two clamped operands and streams a cursor command, "THE SUM IS " and 3 blanked digits to the LCD driver.
// First byte valid 10 cycles after start; each byte is held until char_ready, next byte follows the cycle after transfer.
module lcd_sum_text_gen
   import lcd_pkg::*;
#(
   parameter int         OPW       = 7,
   parameter int         MAX_OPND  = 99,
   parameter logic [7:0] LINE_ADDR = LCD_LINE1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [OPW-1:0]      opnd_a,
   input  logic [OPW-1:0]      opnd_b,
   lcd_sum_text_gen_if.master  char_if,
   output logic                busy,
   output logic                done,
   output logic                clamp_err
);

   localparam logic [OPW-1:0] MAX_V    = OPW'(MAX_OPND);
   localparam logic [3:0]     TXT_LAST = 4'(MSG_LEN - 1);
   localparam logic [3:0]     DIG_LAST = 4'(DIG_LEN - 1);

   lcd_state_t     state;
   logic [3:0]     idx;
   logic [7:0]     data_q;
   logic           cmd_q;
   logic           valid_q;

   logic           a_over;
   logic           b_over;
   logic [OPW-1:0] a_clamp;
   logic [OPW-1:0] b_clamp;
   logic [OPW:0]   sum;
   logic           bcd_start;
   logic           bcd_done;
   logic [3:0]     hund;
   logic [3:0]     tens;
   logic [3:0]     units;
   logic [7:0]     hund_ch;
   logic [7:0]     tens_ch;
   logic [7:0]     units_ch;
   logic           xfer;

   function automatic logic [7:0] text_rom(input logic [3:0] i);
      logic [7:0] c;
      case (i)
         4'd0:    c = 8'h54;
         4'd1:    c = 8'h48;
         4'd2:    c = 8'h45;
         4'd3:    c = 8'h20;
         4'd4:    c = 8'h53;
         4'd5:    c = 8'h55;
         4'd6:    c = 8'h4D;
         4'd7:    c = 8'h20;
         4'd8:    c = 8'h49;
         4'd9:    c = 8'h53;
         4'd10:   c = 8'h20;
         default: c = ASCII_SPACE;
      endcase
      return c;
   endfunction

   assign a_over    = opnd_a > MAX_V;
   assign b_over    = opnd_b > MAX_V;
   assign a_clamp   = a_over ? MAX_V : opnd_a;
   assign b_clamp   = b_over ? MAX_V : opnd_b;
   assign sum       = {1'b0, a_clamp} + {1'b0, b_clamp};

   // The converter samples the sum on the acceptance edge itself, so no separate latch cycle is lost.
   assign bcd_start = (state == ST_IDLE) && start;

   bin2bcd_seq u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (bcd_start),
      .bin   (8'(sum)),
      .done  (bcd_done),
      .hund  (hund),
      .tens  (tens),
      .units (units)
   );

   assign hund_ch  = digit_char(hund, hund == 4'd0);
   assign tens_ch  = digit_char(tens, (hund == 4'd0) && (tens == 4'd0));
   assign units_ch = digit_char(units, 1'b0);

   assign xfer = valid_q && char_if.char_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         data_q    <= '0;
         cmd_q     <= 1'b0;
         valid_q   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         clamp_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  clamp_err <= a_over | b_over;
                  busy      <= 1'b1;
                  state     <= ST_CONV;
               end
            end
            ST_CONV: begin
               if (bcd_done) begin
                  data_q  <= LINE_ADDR;
                  cmd_q   <= 1'b1;
                  valid_q <= 1'b1;
                  state   <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (xfer) begin
                  data_q <= text_rom(4'd0);
                  cmd_q  <= 1'b0;
                  idx    <= '0;
                  state  <= ST_TEXT;
               end
            end
            ST_TEXT: begin
               if (xfer) begin
                  if (idx == TXT_LAST) begin
                     data_q <= hund_ch;
                     idx    <= '0;
                     state  <= ST_DIGS;
                  end else begin
                     data_q <= text_rom(idx + 4'd1);
                     idx    <= idx + 4'd1;
                  end
               end
            end
            ST_DIGS: begin
               if (xfer) begin
                  if (idx == DIG_LAST) begin
                     valid_q <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state   <= ST_FIN;
                  end else begin
                     data_q <= (idx == 4'd0) ? tens_ch : units_ch;
                     idx    <= idx + 4'd1;
                  end
               end
            end
            ST_FIN: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign char_if.char_data  = data_q;
   assign char_if.char_cmd   = cmd_q;
   assign char_if.char_valid = valid_q;

endmodule

// File: tb/tb_lcd_sum_text_gen.sv
// Scoreboard bench for lcd_sum_text_gen: reference messages are queued per run, a monitor pops them on each transfer.
module tb_lcd_sum_text_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [6:0] opnd_a = '0;
   logic [6:0] opnd_b = '0;
   logic       busy;
   logic       done;
   logic       clamp_err;

   lcd_sum_text_gen_if cif ();

   lcd_sum_text_gen #(
      .OPW       (7),
      .MAX_OPND  (99),
      .LINE_ADDR (8'h80)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .opnd_a    (opnd_a),
      .opnd_b    (opnd_b),
      .char_if   (cif),
      .busy      (busy),
      .done      (done),
      .clamp_err (clamp_err)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         xfer_cnt = 0;
   int         done_cnt = 0;
   bit         rdy_rand = 1'b0;
   logic [8:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference message from the arithmetic rules: clamp, add, split into decimal digits, blank leading zeros.
   function automatic void push_expected(input int a, input int b);
      string msg;
      int ac, bc, s, h, t, u;
      msg = "THE SUM IS ";
      ac = (a > 99) ? 99 : a;
      bc = (b > 99) ? 99 : b;
      s  = ac + bc;
      h  = s / 100;
      t  = (s / 10) % 10;
      u  = s % 10;
      exp_q.push_back({1'b1, 8'h80});
      for (int i = 0; i < msg.len(); i++) exp_q.push_back({1'b0, msg[i]});
      exp_q.push_back({1'b0, (h == 0) ? 8'h20 : 8'(8'h30 + h)});
      exp_q.push_back({1'b0, (h == 0 && t == 0) ? 8'h20 : 8'(8'h30 + t)});
      exp_q.push_back({1'b0, 8'(8'h30 + u)});
   endfunction

   initial begin
      cif.char_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cif.char_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      logic       hold_vld;
      logic [8:0] hold_dat;
      logic [8:0] req;
      hold_vld = 1'b0;
      hold_dat = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_vld = 1'b0;
         end else begin
            if (hold_vld)
               check("hold_stable", {cif.char_valid, cif.char_cmd, cif.char_data}, {1'b1, hold_dat});
            if (cif.char_valid && cif.char_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte: got %h required no byte at %0t",
                           {cif.char_cmd, cif.char_data}, $time);
               end else begin
                  req = exp_q.pop_front();
                  check("stream_byte", {cif.char_cmd, cif.char_data}, req);
               end
               xfer_cnt++;
            end
            hold_vld = cif.char_valid && !cif.char_ready;
            hold_dat = {cif.char_cmd, cif.char_data};
            if (done) done_cnt++;
         end
      end
   end

   // mode 0: plain run, 1: extra start pulse during TEXT, 2: reset after the 5th transfer
   task automatic run(input int a, input int b, input int mode);
      int base_x, base_d, lat, cyc;
      logic exp_clamp;
      push_expected(a, b);
      exp_clamp = (a > 99) || (b > 99);
      base_x = xfer_cnt;
      base_d = done_cnt;
      @(posedge clk);
      #1;
      opnd_a = 7'(a);
      opnd_b = 7'(b);
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      opnd_a = 7'($urandom);
      opnd_b = 7'($urandom);
      check("busy_after_start", busy, 1);
      lat = 1;
      while (!cif.char_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("first_valid_latency", lat, 10);

      if (mode == 1) begin
         cyc = 0;
         while (xfer_cnt < base_x + 4 && cyc < 500) begin
            @(posedge clk);
            cyc++;
         end
         #1;
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end

      if (mode == 2) begin
         cyc = 0;
         while (xfer_cnt < base_x + 5 && cyc < 500) begin
            @(posedge clk);
            cyc++;
         end
         check("reset_point_reached", xfer_cnt - base_x, 5);
         #2;
         rst_n = 1'b0;
         #1;
         check("reset_valid_drop", cif.char_valid, 0);
         check("reset_busy_drop", busy, 0);
         exp_q.delete();
         repeat (3) @(posedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         repeat (15) @(posedge clk);
         #1;
         check("no_resume_after_reset", cif.char_valid, 0);
         check("no_done_after_reset", done_cnt, base_d);
         check("clamp_after_reset", clamp_err, 0);
         return;
      end

      cyc = 0;
      while (done_cnt == base_d && cyc < 3000) begin
         @(posedge clk);
         cyc++;
      end
      check("done_seen", done_cnt - base_d, 1);
      repeat (20) @(posedge clk);
      #1;
      check("single_done", done_cnt - base_d, 1);
      check("byte_count", xfer_cnt - base_x, 15);
      check("stream_consumed", exp_q.size(), 0);
      check("clamp_err", clamp_err, exp_clamp);
      check("busy_idle", busy, 0);
      exp_q.delete();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", cif.char_valid, 0);
      check("rst_data", cif.char_data, 0);
      check("rst_cmd", cif.char_cmd, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_clamp", clamp_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      rdy_rand = 1'b0;
      run(20, 40, 0);
      rdy_rand = 1'b1;
      run(99, 99, 0);
      run(0, 0, 0);
      run(120, 3, 0);
      run(1, 1, 0);
      run(55, 60, 1);
      for (int i = 0; i < 8; i++) run($urandom_range(0, 127), $urandom_range(0, 127), 0);
      rdy_rand = 1'b0;
      run(33, 44, 2);
      run(7, 95, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
